id_ex_stage_reg: RTL

- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded control, register-file operands, sign-extended immediate, Rs/Rt/Rd and opcode from ID; presents them to EX and to the forwarding unit (ID_ex_Rs, ID_ex_Rt, OPC).
- Inserts one bubble per load-use hazard and freezes PC/IF-ID meanwhile.
- Handles branch flush and counts stall cycles.

---
 rtl/id_ex_stage_reg_if.sv | 63 ++++++
 rtl/id_ex_stage_reg.sv | 99 +++++++++
 2 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID-side fields in, registered EX-side fields
// and hazard outputs back out to the front-end and forwarding unit.
interface id_ex_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) ();
  logic             id_valid;
  logic [4:0]       id_Rs;
  logic [4:0]       id_Rt;
  logic [4:0]       id_Rd;
  logic [5:0]       id_OPC;
  logic [WIDTH-1:0] id_readData1;
  logic [WIDTH-1:0] id_readData2;
  logic [WIDTH-1:0] id_signExt;
  logic             id_regWrite;
  logic             id_memRead;
  logic             id_memWrite;
  logic             id_memToReg;
  logic             id_aluSrc;
  logic             id_regDst;
  logic [2:0]       id_aluOp;
  logic             flush;

  logic             ex_valid;
  logic [4:0]       ex_Rs;
  logic [4:0]       ex_Rt;
  logic [4:0]       ex_Rd;
  logic [5:0]       ex_OPC;
  logic [WIDTH-1:0] ex_readData1;
  logic [WIDTH-1:0] ex_readData2;
  logic [WIDTH-1:0] ex_signExt;
  logic             ex_regWrite;
  logic             ex_memRead;
  logic             ex_memWrite;
  logic             ex_memToReg;
  logic             ex_aluSrc;
  logic             ex_regDst;
  logic [2:0]       ex_aluOp;
  logic             stall;
  logic             pc_write;
  logic             if_id_write;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_Rs, id_Rt, id_Rd, id_OPC, id_readData1, id_readData2,
           id_signExt, id_regWrite, id_memRead, id_memWrite, id_memToReg,
           id_aluSrc, id_regDst, id_aluOp, flush,
    input  ex_valid, ex_Rs, ex_Rt, ex_Rd, ex_OPC, ex_readData1, ex_readData2,
           ex_signExt, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
           ex_aluSrc, ex_regDst, ex_aluOp, stall, pc_write, if_id_write,
           stall_count
  );

  modport slave (
    input  id_valid, id_Rs, id_Rt, id_Rd, id_OPC, id_readData1, id_readData2,
           id_signExt, id_regWrite, id_memRead, id_memWrite, id_memToReg,
           id_aluSrc, id_regDst, id_aluOp, flush,
    output ex_valid, ex_Rs, ex_Rt, ex_Rd, ex_OPC, ex_readData1, ex_readData2,
           ex_signExt, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
           ex_aluSrc, ex_regDst, ex_aluOp, stall, pc_write, if_id_write,
           stall_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle bubble
// insertion, branch flush and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [5:0]       OPC_RTYPE = 6'b000000;
  localparam logic [5:0]       OPC_BEQ   = 6'b000100;
  localparam logic [5:0]       OPC_BNE   = 6'b000101;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Control bundle layout: {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[2:0]}
  localparam int CTRL_W      = 9;
  localparam int MEMREAD_BIT = 7;

  logic              valid_reg;
  logic [4:0]        rs_reg;
  logic [4:0]        rt_reg;
  logic [4:0]        rd_reg;
  logic [5:0]        opc_reg;
  logic [WIDTH-1:0]  read_data1_reg;
  logic [WIDTH-1:0]  read_data2_reg;
  logic [WIDTH-1:0]  sign_ext_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [CNT_W-1:0]  stall_count_reg;

  logic [CTRL_W-1:0] id_ctrl;
  logic              uses_rt;
  logic              stall;

  assign id_ctrl = {bus.id_regWrite, bus.id_memRead, bus.id_memWrite,
                    bus.id_memToReg, bus.id_aluSrc, bus.id_regDst, bus.id_aluOp};

  always_comb begin
    uses_rt = (bus.id_OPC == OPC_RTYPE) || bus.id_memWrite ||
              (bus.id_OPC == OPC_BEQ) || (bus.id_OPC == OPC_BNE);
    stall   = bus.id_valid && valid_reg && ctrl_reg[MEMREAD_BIT] &&
              (rt_reg != 5'd0) &&
              ((rt_reg == bus.id_Rs) || (uses_rt && (rt_reg == bus.id_Rt)));
  end

  // Reset, flush and stall all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || stall) begin
      valid_reg      <= 1'b0;
      rs_reg         <= 5'd0;
      rt_reg         <= 5'd0;
      rd_reg         <= 5'd0;
      opc_reg        <= 6'd0;
      read_data1_reg <= '0;
      read_data2_reg <= '0;
      sign_ext_reg   <= '0;
      ctrl_reg       <= '0;
    end else begin
      valid_reg      <= bus.id_valid;
      rs_reg         <= bus.id_Rs;
      rt_reg         <= bus.id_Rt;
      rd_reg         <= bus.id_Rd;
      opc_reg        <= bus.id_OPC;
      read_data1_reg <= bus.id_readData1;
      read_data2_reg <= bus.id_readData2;
      sign_ext_reg   <= bus.id_signExt;
      ctrl_reg       <= bus.id_valid ? id_ctrl : '0;
    end
  end

  // A flushed hazard never becomes a bubble of its own, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (!bus.flush && stall && (stall_count_reg != CNT_MAX)) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.ex_valid     = valid_reg;
  assign bus.ex_Rs        = rs_reg;
  assign bus.ex_Rt        = rt_reg;
  assign bus.ex_Rd        = rd_reg;
  assign bus.ex_OPC       = opc_reg;
  assign bus.ex_readData1 = read_data1_reg;
  assign bus.ex_readData2 = read_data2_reg;
  assign bus.ex_signExt   = sign_ext_reg;
  assign bus.ex_regWrite  = ctrl_reg[8];
  assign bus.ex_memRead   = ctrl_reg[7];
  assign bus.ex_memWrite  = ctrl_reg[6];
  assign bus.ex_memToReg  = ctrl_reg[5];
  assign bus.ex_aluSrc    = ctrl_reg[4];
  assign bus.ex_regDst    = ctrl_reg[3];
  assign bus.ex_aluOp     = ctrl_reg[2:0];
  assign bus.stall        = stall;
  assign bus.pc_write     = !stall;
  assign bus.if_id_write  = !stall;
  assign bus.stall_count  = stall_count_reg;
endmodule
